axi4_mem_master: RTL and testbench
==================================

AXI4_MEM_MASTER -- requirements
Module: axi4_mem_master

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd0, driven on arid/awid.
REQ-002 SHALL have port aclk  in  1  clock; all logic on posedge aclk.
REQ-003 SHALL have port aresetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  in  1  request present.
REQ-005 SHALL have port req_ready  out  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_write  in  1  1 = write burst, 0 = read burst.
REQ-007 SHALL have port req_addr  in  32  burst start byte address, 8-byte aligned.
REQ-008 SHALL have port req_len  in  8  beats minus one (0..255).
REQ-009 SHALL have port wd_valid  in  1  write-data beat available.
REQ-010 SHALL have port wd_ready  out  1  write-data beat consumed.
REQ-011 SHALL have port wd_data  in  64  write-data beat.
REQ-012 SHALL have port wd_strb  in  8  byte enables of the beat.
REQ-013 SHALL have port rsp_valid  out  1  response beat, one-cycle pulse, no backpressure.
REQ-014 SHALL have port rsp_data  out  64  read data (0 for write completion).
REQ-015 SHALL have port rsp_last  out  1  final response of the request.
REQ-016 SHALL have port rsp_err  out  1  error flag of that response beat.
REQ-017 SHALL have ports araddr/awaddr  out  32  burst address.
REQ-018 SHALL have ports arlen/awlen  out  8  burst length.
REQ-019 SHALL have ports arvalid/awvalid  out  1, and arready/awready  in  1, address handshake.
REQ-020 SHALL have ports arid/awid out 4, arsize/awsize out 3 (=3'b011), arburst/awburst out 2 (=2'b01 INCR), arlock/awlock out 2, arcache/awcache out 4, arprot/awprot out 3 (all =0).
REQ-021 SHALL have ports rdata in 64, rresp in 2, rlast in 1, rid in 4 (ignored), rvalid in 1, rready out 1.
REQ-022 SHALL have ports wdata out 64, wstrb out 8, wlast out 1, wid out 4 (=AXI_ID), wvalid out 1, wready in 1.
REQ-023 SHALL have ports bresp in 2, bid in 4 (ignored), bvalid in 1, bready out 1.

Function
REQ-024 SHALL implement FSM states IDLE, AR, R, AW, W, B; only IDLE asserts req_ready.
REQ-025 IDLE: on req_valid&&req_ready SHALL latch addr/len/write, clear 8-bit beat counter, go to AW if write else AR next cycle.
REQ-026 AR/AW: arvalid/awvalid SHALL be 1 with address/len stable until the cycle ready is sampled high; then go to R/W.
REQ-027 R: rready SHALL be 1; each rvalid&&rready beat SHALL produce, next cycle, rsp_valid=1, rsp_data=rdata, rsp_err=rresp[1] OR (rlast != (cnt==len)), rsp_last=(cnt==len).
REQ-028 R: beat with cnt==len SHALL return FSM to IDLE; earlier beats increment cnt; early rlast ignored except for rsp_err.
REQ-029 W: wvalid=wd_valid, wd_ready=wready, wdata=wd_data, wstrb=wd_strb combinationally; wlast=(cnt==len); outside W wvalid=wd_ready=0.
REQ-030 W: each wvalid&&wready beat SHALL increment cnt; beat with cnt==len SHALL go to B.
REQ-031 B: bready SHALL be 1; on bvalid SHALL pulse next cycle rsp_valid=1, rsp_last=1, rsp_data=0, rsp_err=bresp[1]; go to IDLE.
REQ-032 Counter SHALL not wrap: len=255 yields exactly 256 beats, cnt 0..255.
REQ-033 Back-to-back: next request SHALL be accepted no earlier than the first IDLE cycle after the final beat/B handshake.
REQ-034 AW SHALL complete before any W beat; AR and AW SHALL never be asserted together.

Reset
REQ-035 aresetn low at a posedge SHALL force IDLE, cnt=0, and all valid/ready/rsp outputs 0 except req_ready=0 during reset, 1 in first cycle after.
REQ-036 Reset mid-burst SHALL abandon the transaction with no further rsp pulses.

Verification
REQ-037 Read len=0 addr 0x80000000, rdata 0x1122334455667788 rlast=1 -> one rsp_valid, rsp_last=1, rsp_err=0, data matches.
REQ-038 Read len=3 with rvalid gaps -> four rsp pulses in order, rsp_last only on 4th, arlen=3.
REQ-039 Write len=1, wready stalled 2 cycles, bresp=2'b10 -> two W beats, wlast on 2nd, rsp_err=1, rsp_last=1.
REQ-040 Read len=1 with rlast on first beat -> rsp_err=1 on beat 0, FSM still waits for beat 1.
REQ-041 Assert aresetn=0 during W beat 2 of len=7 -> wvalid=0 next cycle, req_ready=1 after release, no rsp pulse.
REQ-042 Read len=255 -> 256 rsp pulses, rsp_last only on 256th, FSM IDLE after.

Source files
------------

// File: rtl/axi4_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : axi4_mem_master
// Purpose  : Converts simple burst requests (read or write, 1..256 beats of
//            64 bits) into single AXI4 INCR bursts and returns one response
//            beat per read beat, or one completion beat per write burst.
// Ports    : aclk/aresetn       - clock, synchronous active-low reset
//            req_*              - request channel (valid/ready, write, addr, len)
//            wd_*               - write-data source (valid/ready, data, strb)
//            rsp_*              - response pulses (valid, data, last, err)
//            ar*/r*/aw*/w*/b*   - AXI4 master channels
// Revision : 1.0 - initial release
// ============================================================================
module axi4_mem_master #(
  parameter logic [3:0] AXI_ID = 4'd0
) (
  input  logic        aclk,
  input  logic        aresetn,
  // request channel
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  // write-data source
  input  logic        wd_valid,
  output logic        wd_ready,
  input  logic [63:0] wd_data,
  input  logic [7:0]  wd_strb,
  // response channel
  output logic        rsp_valid,
  output logic [63:0] rsp_data,
  output logic        rsp_last,
  output logic        rsp_err,
  // AXI read address
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI read data
  input  logic [3:0]  rid,
  input  logic [63:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // AXI write data
  output logic [3:0]  wid,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // AXI write response
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AR   = 3'd1;
  localparam logic [2:0] S_R    = 3'd2;
  localparam logic [2:0] S_AW   = 3'd3;
  localparam logic [2:0] S_W    = 3'd4;
  localparam logic [2:0] S_B    = 3'd5;

  logic [2:0]  state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic [31:0] addr_q,      addr_d;
  logic [7:0]  len_q,       len_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_data_q,  rsp_data_d;
  logic        rsp_last_q,  rsp_last_d;
  logic        rsp_err_q,   rsp_err_d;

  // The counter compares against len instead of counting down, so len=255
  // reaches 255 without ever wrapping and gives exactly 256 beats.
  logic last_beat;
  assign last_beat = (cnt_q == len_q);

  // IDs and the low response bit carry no information for this master.
  logic unused_inputs;
  assign unused_inputs = ^{rid, bid, rresp[0], bresp[0]};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= 32'd0;
      len_q       <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 64'd0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = 64'd0;
    rsp_last_d  = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          len_d   = req_len;
          cnt_d   = 8'd0;
          state_d = req_write ? S_AW : S_AR;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
      end
      S_R: begin
        if (rvalid) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rdata;
          rsp_last_d  = last_beat;
          // A slave whose rlast disagrees with the beat count is reported as
          // an error; the burst still runs to the requested length.
          rsp_err_d   = rresp[1] | (rlast != last_beat);
          if (last_beat) state_d = S_IDLE;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_AW: begin
        if (awready) state_d = S_W;
      end
      S_W: begin
        if (wd_valid && wready) begin
          if (last_beat) state_d = S_B;
          else           cnt_d   = cnt_q + 8'd1;
        end
      end
      S_B: begin
        if (bvalid) begin
          rsp_valid_d = 1'b1;
          rsp_last_d  = 1'b1;
          rsp_err_d   = bresp[1];
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    // Gated with aresetn so the request port reads as busy while reset is held.
    req_ready = (state_q == S_IDLE) && aresetn;
    arvalid   = (state_q == S_AR);
    awvalid   = (state_q == S_AW);
    rready    = (state_q == S_R);
    bready    = (state_q == S_B);
    wvalid    = 1'b0;
    wd_ready  = 1'b0;
    if (state_q == S_W) begin
      wvalid   = wd_valid;
      wd_ready = wready;
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = 3'b011;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

  assign awid    = AXI_ID;
  assign awaddr  = addr_q;
  assign awlen   = len_q;
  assign awsize  = 3'b011;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0000;
  assign awprot  = 3'b000;

  assign wid     = AXI_ID;
  assign wdata   = wd_data;
  assign wstrb   = wd_strb;
  assign wlast   = last_beat;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4_mem_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_mem_master
// Purpose  : Self-checking bench for axi4_mem_master. The bench plays the AXI
//            slave and the request/write-data source, predicts every response
//            beat (data, last, err, arrival cycle) from the burst rules, and
//            compares against a monitor of rsp_valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi4_mem_master;

  localparam logic [3:0] AXI_ID = 4'hA;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic        aresetn, req_valid, req_ready, req_write;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        wd_valid, wd_ready;
  logic [63:0] wd_data;
  logic [7:0]  wd_strb;
  logic        rsp_valid, rsp_last, rsp_err;
  logic [63:0] rsp_data;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache;
  logic [31:0] araddr, awaddr;
  logic [7:0]  arlen, awlen, wstrb;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, awvalid, awready, rlast, rvalid, rready;
  logic [63:0] rdata, wdata;
  logic        wlast, wvalid, wready, bvalid, bready;

  axi4_mem_master #(.AXI_ID(AXI_ID)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] d;
    logic        l;
    logic        e;
    int unsigned c;
  } rsp_t;

  rsp_t mon_q[$];
  rsp_t mon_e;

  // Response monitor: every pulse is recorded with the cycle it appeared in.
  always @(negedge aclk) begin
    if (rsp_valid === 1'b1) begin
      mon_e.d = rsp_data; mon_e.l = rsp_last; mon_e.e = rsp_err; mon_e.c = cyc;
      mon_q.push_back(mon_e);
    end
  end

  // AR and AW must never be offered together.
  always @(negedge aclk) begin
    if (arvalid === 1'b1 && awvalid === 1'b1) begin
      errors++;
      $display("FAIL ar_aw_overlap arvalid=%b awvalid=%b required not both 1", arvalid, awvalid);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge aclk); #1;
  endtask

  // --------------------------------------------------------------------------
  // Read burst: request, AR handshake, len+1 R beats, then response compare.
  // early >= 0 raises rlast on that beat as well as the real last beat.
  // --------------------------------------------------------------------------
  task automatic do_read(input logic [31:0] a, input logic [7:0] l, input int gap_max,
                         input int early, input int err_pct, input logic [63:0] d0);
    rsp_t exp_q[$];
    rsp_t e;
    logic [63:0] d;
    logic [1:0]  rr;
    logic        lst, fin;
    int          n;
    tick();
    req_valid = 1'b1; req_write = 1'b0; req_addr = a; req_len = l;
    n = 0;
    @(negedge aclk);
    while (req_ready !== 1'b1 && n < 20) begin tick(); @(negedge aclk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_accept req_ready=%b required 1", req_ready); end
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom);
    repeat ($urandom_range(0, 3)) begin
      @(negedge aclk);
      checks++;
      if ({arvalid, awvalid, rready, req_ready} !== 4'b1000) begin
        errors++; $display("FAIL rd_ar_wait ar/aw/rready/req_ready=%b required 1000", {arvalid, awvalid, rready, req_ready});
      end
      tick();
    end
    arready = 1'b1;
    @(negedge aclk);
    checks++;
    if ({arvalid, awvalid, araddr, arlen, arid, arsize, arburst, arlock, arcache, arprot} !==
        {1'b1, 1'b0, a, l, AXI_ID, 3'b011, 2'b01, 2'b00, 4'h0, 3'h0}) begin
      errors++;
      $display("FAIL rd_ar_fields got v=%b addr=%h len=%0d id=%h size=%0d burst=%0d required v=1 addr=%h len=%0d id=%h size=3 burst=1",
               arvalid, araddr, arlen, arid, arsize, arburst, a, l, AXI_ID);
    end
    tick();
    arready = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        @(negedge aclk);
        checks++;
        if ({rready, req_ready} !== 2'b10) begin
          errors++; $display("FAIL rd_gap beat %0d rready/req_ready=%b required 10", i, {rready, req_ready});
        end
        tick();
      end
      d   = (i == 0 && d0 != 64'd0) ? d0 : {$urandom, $urandom};
      rr  = ($urandom_range(0, 99) < err_pct) ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      fin = (i == int'(l));
      lst = fin || (i == early);
      rvalid = 1'b1; rdata = d; rresp = rr; rlast = lst;
      @(negedge aclk);
      checks++;
      if ({rready, req_ready} !== 2'b10) begin
        errors++; $display("FAIL rd_beat %0d rready/req_ready=%b required 10", i, {rready, req_ready});
      end
      e.d = d; e.l = fin; e.e = rr[1] | (lst != fin); e.c = cyc + 1;
      exp_q.push_back(e);
      tick();
      rvalid = 1'b0; rlast = 1'b0; rdata = {$urandom, $urandom};
    end
    @(negedge aclk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rd_idle_after req_ready=%b required 1", req_ready); end
    tick();
    @(negedge aclk);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rd_rsp_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) begin
      checks++;
      if ({mon_q[k].d, mon_q[k].l, mon_q[k].e} !== {exp_q[k].d, exp_q[k].l, exp_q[k].e} || mon_q[k].c != exp_q[k].c) begin
        errors++;
        $display("FAIL rd_rsp[%0d] got d=%h l=%b e=%b cyc=%0d required d=%h l=%b e=%b cyc=%0d", k,
                 mon_q[k].d, mon_q[k].l, mon_q[k].e, mon_q[k].c, exp_q[k].d, exp_q[k].l, exp_q[k].e, exp_q[k].c);
      end
    end
    mon_q.delete();
  endtask

  // --------------------------------------------------------------------------
  // Write burst: request, AW handshake (W offered early and must stay off),
  // len+1 W beats with stalls, B handshake, completion compare.
  // stall >= 0 fixes the number of wready-low cycles before every beat.
  // --------------------------------------------------------------------------
  task automatic do_write(input logic [31:0] a, input logic [7:0] l, input int stall,
                          input logic [1:0] br);
    rsp_t exp_q[$];
    rsp_t e;
    logic [63:0] d;
    logic [7:0]  s;
    logic        fin;
    int          n, st, mode;
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = a; req_len = l;
    n = 0;
    @(negedge aclk);
    while (req_ready !== 1'b1 && n < 20) begin tick(); @(negedge aclk); n++; end
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_accept req_ready=%b required 1", req_ready); end
    tick();
    req_valid = 1'b0; req_addr = $urandom; req_len = 8'($urandom);
    wd_valid = 1'b1; wd_data = {$urandom, $urandom}; wready = 1'b1;
    repeat ($urandom_range(0, 3)) begin
      @(negedge aclk);
      checks++;
      if ({awvalid, arvalid, wvalid, wd_ready} !== 4'b1000) begin
        errors++; $display("FAIL wr_aw_wait aw/ar/wvalid/wd_ready=%b required 1000", {awvalid, arvalid, wvalid, wd_ready});
      end
      tick();
    end
    awready = 1'b1;
    @(negedge aclk);
    checks++;
    if ({awvalid, arvalid, wvalid, awaddr, awlen, awid, awsize, awburst, awlock, awcache, awprot} !==
        {1'b1, 1'b0, 1'b0, a, l, AXI_ID, 3'b011, 2'b01, 2'b00, 4'h0, 3'h0}) begin
      errors++;
      $display("FAIL wr_aw_fields got v=%b wvalid=%b addr=%h len=%0d id=%h size=%0d burst=%0d required v=1 wvalid=0 addr=%h len=%0d id=%h size=3 burst=1",
               awvalid, wvalid, awaddr, awlen, awid, awsize, awburst, a, l, AXI_ID);
    end
    tick();
    awready = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      d = {$urandom, $urandom}; s = 8'($urandom); fin = (i == int'(l));
      wd_data = d; wd_strb = s;
      st = (stall < 0) ? $urandom_range(0, 2) : stall;
      repeat (st) begin
        mode = (stall < 0) ? $urandom_range(0, 2) : 0;
        wd_valid = (mode == 0); wready = (mode == 1);
        @(negedge aclk);
        checks++;
        if ({wvalid, wd_ready, wlast} !== {wd_valid, wready, fin}) begin
          errors++; $display("FAIL wr_stall beat %0d wvalid/wd_ready/wlast=%b required %b", i, {wvalid, wd_ready, wlast}, {wd_valid, wready, fin});
        end
        tick();
      end
      wd_valid = 1'b1; wready = 1'b1;
      @(negedge aclk);
      checks++;
      if ({wvalid, wd_ready, wdata, wstrb, wlast, wid, awvalid} !== {2'b11, d, s, fin, AXI_ID, 1'b0}) begin
        errors++;
        $display("FAIL wr_beat %0d got v=%b rdy=%b d=%h s=%h last=%b id=%h required v=1 rdy=1 d=%h s=%h last=%b id=%h",
                 i, wvalid, wd_ready, wdata, wstrb, wlast, wid, d, s, fin, AXI_ID);
      end
      tick();
    end
    repeat ($urandom_range(0, 2)) begin
      @(negedge aclk);
      checks++;
      if ({wvalid, wd_ready, bready, req_ready} !== 4'b0010) begin
        errors++; $display("FAIL wr_b_wait wvalid/wd_ready/bready/req_ready=%b required 0010", {wvalid, wd_ready, bready, req_ready});
      end
      tick();
    end
    bvalid = 1'b1; bresp = br;
    @(negedge aclk);
    checks++;
    if ({wvalid, wd_ready, bready} !== 3'b001) begin
      errors++; $display("FAIL wr_b wvalid/wd_ready/bready=%b required 001", {wvalid, wd_ready, bready});
    end
    e.d = 64'd0; e.l = 1'b1; e.e = br[1]; e.c = cyc + 1;
    exp_q.push_back(e);
    tick();
    bvalid = 1'b0; wd_valid = 1'b0; wready = 1'b0;
    @(negedge aclk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL wr_idle_after req_ready=%b required 1", req_ready); end
    tick();
    @(negedge aclk);
    checks++;
    if (mon_q.size() != exp_q.size()) begin
      errors++; $display("FAIL wr_rsp_count got %0d required %0d", mon_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++) begin
      checks++;
      if ({mon_q[k].d, mon_q[k].l, mon_q[k].e} !== {exp_q[k].d, exp_q[k].l, exp_q[k].e} || mon_q[k].c != exp_q[k].c) begin
        errors++;
        $display("FAIL wr_rsp[%0d] got d=%h l=%b e=%b cyc=%0d required d=%h l=%b e=%b cyc=%0d", k,
                 mon_q[k].d, mon_q[k].l, mon_q[k].e, mon_q[k].c, exp_q[k].d, exp_q[k].l, exp_q[k].e, exp_q[k].c);
      end
    end
    mon_q.delete();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    a[2:0] = 3'b000;
    return a;
  endfunction

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (2) tick();
    @(negedge aclk);
    checks++;
    if ({req_ready, arvalid, awvalid, rready, wvalid, wd_ready, bready, rsp_valid} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs got %b required 00000000",
                         {req_ready, arvalid, awvalid, rready, wvalid, wd_ready, bready, rsp_valid});
    end
    tick();
    aresetn = 1'b1;
    @(negedge aclk);
    checks++;
    if ({req_ready, arvalid, awvalid, rready, wvalid, bready, rsp_valid} !== 7'b1000000) begin
      errors++; $display("FAIL reset_release got %b required 1000000",
                         {req_ready, arvalid, awvalid, rready, wvalid, bready, rsp_valid});
    end
    mon_q.delete();
  endtask

  task automatic test_read_single();
    do_read(32'h8000_0000, 8'd0, 0, -1, 0, 64'h1122_3344_5566_7788);
  endtask

  task automatic test_read_gaps();
    do_read(rand_addr(), 8'd3, 3, -1, 0, 64'd0);
  endtask

  task automatic test_write_stall();
    do_write(rand_addr(), 8'd1, 2, 2'b10);
  endtask

  task automatic test_read_early_rlast();
    do_read(rand_addr(), 8'd1, 2, 0, 0, 64'd0);
  endtask

  task automatic test_reset_mid_burst();
    tick();
    req_valid = 1'b1; req_write = 1'b1; req_addr = rand_addr(); req_len = 8'd7;
    @(negedge aclk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_accept req_ready=%b required 1", req_ready); end
    tick();
    req_valid = 1'b0; awready = 1'b1;
    @(negedge aclk);
    checks++;
    if (awvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_aw awvalid=%b required 1", awvalid); end
    tick();
    awready = 1'b0; wd_valid = 1'b1; wready = 1'b1; wd_data = {$urandom, $urandom};
    repeat (2) begin
      @(negedge aclk);
      checks++;
      if (wvalid !== 1'b1) begin errors++; $display("FAIL rst_mid_beat wvalid=%b required 1", wvalid); end
      tick();
    end
    aresetn = 1'b0;
    @(negedge aclk);
    checks++;
    if ({wvalid, wlast} !== 2'b10) begin errors++; $display("FAIL rst_mid_beat2 wvalid/wlast=%b required 10", {wvalid, wlast}); end
    tick();
    @(negedge aclk);
    checks++;
    if ({wvalid, wd_ready, req_ready, awvalid, bready, rsp_valid} !== 6'b000000) begin
      errors++; $display("FAIL rst_mid_held got %b required 000000", {wvalid, wd_ready, req_ready, awvalid, bready, rsp_valid});
    end
    tick();
    aresetn = 1'b1; wd_valid = 1'b0; wready = 1'b0;
    @(negedge aclk);
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release req_ready=%b required 1", req_ready); end
    repeat (5) tick();
    @(negedge aclk);
    checks++;
    if (mon_q.size() != 0) begin errors++; $display("FAIL rst_mid_no_rsp got %0d pulses required 0", mon_q.size()); end
    mon_q.delete();
  endtask

  task automatic test_read_long();
    do_read(rand_addr(), 8'd255, 0, -1, 10, 64'd0);
  endtask

  task automatic test_back_to_back();
    do_write(rand_addr(), 8'd0, 0, 2'b00);
    do_read(rand_addr(), 8'd0, 0, -1, 0, 64'd0);
    do_write(rand_addr(), 8'd2, 0, 2'b11);
    do_read(rand_addr(), 8'd2, 0, -1, 0, 64'd0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 16; t++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(rand_addr(), 8'($urandom_range(0, 15)), -1, 2'($urandom_range(0, 3)));
      else
        do_read(rand_addr(), 8'($urandom_range(0, 15)), 3,
                ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1, 20, 64'd0);
    end
  endtask

  initial begin
    aresetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_len = 8'd0;
    wd_valid = 1'b0; wd_data = 64'd0; wd_strb = 8'd0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0;
    rid = 4'h3; rdata = 64'd0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    bid = 4'h5; bresp = 2'b00; bvalid = 1'b0;

    test_reset();
    test_read_single();
    test_read_gaps();
    test_write_stall();
    test_read_early_rlast();
    test_reset_mid_burst();
    test_read_long();
    test_back_to_back();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
